// File: rtl/spn_cu_host.sv
// Host-side sequencer for spn_cu_top: holds the key, issues one encrypt or
// decrypt command at a time, waits a fixed LATENCY, and returns the captured
// result over a valid/ready response channel.

package spn_cu_pkg;
  typedef enum logic [1:0] {
    no_op   = 2'd0,
    encrypt = 2'd1,
    decrypt = 2'd2
  } opcode_t;

  typedef enum logic [1:0] {
    not_valid             = 2'd0,
    successful_encryption = 2'd1,
    successful_decryption = 2'd2,
    undefined_result      = 2'd3
  } valid_t;
endpackage

module spn_cu_host
  import spn_cu_pkg::*;
#(
  parameter int unsigned LATENCY = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          key_wr,
  input  logic [31:0]   key_in,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_op,
  input  logic [15:0]   req_data,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [15:0]   rsp_data,
  output logic          rsp_err,
  output opcode_t       cu_opcode,
  output logic [15:0]   cu_data_in,
  output logic [31:0]   cu_key,
  input  valid_t        cu_valid,
  input  logic [15:0]   cu_data_out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Counter value seen on the edge that completes the wait (edge k+LATENCY).
  localparam logic [3:0] LAST_CNT = 4'(LATENCY - 1);

  state_t      state_q, state_d;
  logic        key_loaded_q, key_loaded_d;
  logic [31:0] key_q, key_d;
  opcode_t     opcode_q, opcode_d;
  logic [15:0] data_in_q, data_in_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [15:0] rsp_data_q, rsp_data_d;
  logic        rsp_err_q, rsp_err_d;
  logic [3:0]  cnt_q, cnt_d;
  valid_t      expected_code;

  // A key write in IDLE takes priority over a request on the same edge.
  assign req_ready  = (state_q == IDLE) && key_loaded_q && !key_wr;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_err    = rsp_err_q;
  assign cu_opcode  = opcode_q;
  assign cu_data_in = data_in_q;
  assign cu_key     = key_q;

  // The opcode is held through WAIT, so it tells us which success code to expect.
  assign expected_code = (opcode_q == decrypt) ? successful_decryption
                                               : successful_encryption;

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      key_loaded_q <= 1'b0;
      key_q        <= '0;
      opcode_q     <= no_op;
      data_in_q    <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
      rsp_err_q    <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      key_loaded_q <= key_loaded_d;
      key_q        <= key_d;
      opcode_q     <= opcode_d;
      data_in_q    <= data_in_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      rsp_err_q    <= rsp_err_d;
      cnt_q        <= cnt_d;
    end
  end

  // Next-state logic: accept in IDLE, count in WAIT, hand off in RESP.
  always_comb begin
    state_d      = state_q;
    key_loaded_d = key_loaded_q;
    key_d        = key_q;
    opcode_d     = opcode_q;
    data_in_d    = data_in_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_data_d   = rsp_data_q;
    rsp_err_d    = rsp_err_q;
    cnt_d        = cnt_q;

    case (state_q)
      IDLE: begin
        if (key_wr) begin
          key_d        = key_in;
          key_loaded_d = 1'b1;
        end else if (req_valid && req_ready) begin
          opcode_d  = req_op ? decrypt : encrypt;
          data_in_d = req_data;
          cnt_d     = '0;
          state_d   = WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == LAST_CNT) begin
          rsp_data_d  = cu_data_out;
          rsp_err_d   = (cu_valid != expected_code);
          opcode_d    = no_op;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d  = IDLE;
        opcode_d = no_op;
      end
    endcase
  end

endmodule

// File: tb/tb_spn_cu_host.sv
// Directed testbench for spn_cu_host; the bench plays the role of the
// spn_cu_top stub by driving cu_valid / cu_data_out directly.

module tb_spn_cu_host;
  import spn_cu_pkg::*;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        key_wr;
  logic [31:0] key_in;
  logic        req_valid;
  logic        req_ready;
  logic        req_op;
  logic [15:0] req_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_data;
  logic        rsp_err;
  opcode_t     cu_opcode;
  logic [15:0] cu_data_in;
  logic [31:0] cu_key;
  valid_t      cu_valid;
  logic [15:0] cu_data_out;

  int tests_run = 0;
  int tests_failed = 0;

  spn_cu_host #(.LATENCY(LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .key_wr     (key_wr),
    .key_in     (key_in),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_data   (req_data),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_err    (rsp_err),
    .cu_opcode  (cu_opcode),
    .cu_data_in (cu_data_in),
    .cu_key     (cu_key),
    .cu_valid   (cu_valid),
    .cu_data_out(cu_data_out)
  );

  always #5 clk = ~clk;

  // Advance past the next rising edge and settle 1 time unit.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; key_wr = 0; key_in = '0; req_valid = 0; req_op = 0;
    req_data = '0; rsp_ready = 0; cu_valid = not_valid; cu_data_out = '0;
    #23;
    rst = 1'b1;
    tick();
    tests_run++;
    if (req_ready !== 1'b0 || rsp_valid !== 1'b0 || cu_opcode !== no_op ||
        cu_key !== 32'h0 || cu_data_in !== 16'h0 || rsp_data !== 16'h0 || rsp_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_state: req_ready=%b rsp_valid=%b op=%0d key=%h din=%h rdata=%h err=%b required 0/0/0/0/0/0/0",
               req_ready, rsp_valid, cu_opcode, cu_key, cu_data_in, rsp_data, rsp_err);
    end
    $display("[TB] reset: req_ready=%b rsp_valid=%b", req_ready, rsp_valid);
  endtask

  task automatic test_no_key();
    req_valid = 1; req_op = 0; req_data = 16'h1111;
    for (int i = 0; i < 10; i++) begin
      #1;
      tests_run++;
      if (req_ready !== 1'b0 || cu_opcode !== no_op) begin
        tests_failed++;
        $display("FAIL no_key cycle %0d: req_ready=%b op=%0d required 0/no_op", i, req_ready, cu_opcode);
      end
      tick();
    end
    req_valid = 0;
    $display("[TB] no_key: 10 cycles req_valid=1, req_ready=%b", req_ready);
  endtask

  task automatic test_encrypt();
    key_wr = 1; key_in = 32'h1234ABCD;
    tick();
    key_wr = 0;
    cu_data_out = 16'hC3E1; cu_valid = successful_encryption;
    req_valid = 1; req_op = 0; req_data = 16'h5A5A;
    #1;
    tests_run++;
    if (req_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL enc_ready: req_ready=%b required 1", req_ready);
    end
    tick();                      // edge k
    req_valid = 0;
    tests_run++;
    if (cu_opcode !== encrypt || cu_data_in !== 16'h5A5A || cu_key !== 32'h1234ABCD || rsp_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL enc_k: op=%0d din=%h key=%h rsp_valid=%b required encrypt/5a5a/1234abcd/0",
               cu_opcode, cu_data_in, cu_key, rsp_valid);
    end
    tick();                      // edge k+1
    tests_run++;
    if (cu_opcode !== encrypt || rsp_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL enc_k1: op=%0d rsp_valid=%b required encrypt/0", cu_opcode, rsp_valid);
    end
    tick();                      // edge k+2
    tests_run++;
    if (rsp_valid !== 1'b1 || rsp_data !== 16'hC3E1 || rsp_err !== 1'b0 || cu_opcode !== no_op) begin
      tests_failed++;
      $display("FAIL enc_resp: rsp_valid=%b data=%h err=%b op=%0d required 1/c3e1/0/no_op",
               rsp_valid, rsp_data, rsp_err, cu_opcode);
    end
    rsp_ready = 1;
    tick();
    rsp_ready = 0;
    tests_run++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || rsp_data !== 16'hC3E1) begin
      tests_failed++;
      $display("FAIL enc_done: rsp_valid=%b req_ready=%b data=%h required 0/1/c3e1", rsp_valid, req_ready, rsp_data);
    end
    $display("[TB] encrypt 5a5a -> data=%h err=%b", rsp_data, rsp_err);
  endtask

  task automatic test_decrypt_err();
    cu_data_out = 16'h5A5A; cu_valid = successful_encryption;
    req_valid = 1; req_op = 1; req_data = 16'hC3E1;
    tick();
    req_valid = 0;
    tests_run++;
    if (cu_opcode !== decrypt || cu_data_in !== 16'hC3E1) begin
      tests_failed++;
      $display("FAIL dec_k: op=%0d din=%h required decrypt/c3e1", cu_opcode, cu_data_in);
    end
    tick(); tick();
    tests_run++;
    if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_data !== 16'h5A5A) begin
      tests_failed++;
      $display("FAIL dec_err: rsp_valid=%b err=%b data=%h required 1/1/5a5a", rsp_valid, rsp_err, rsp_data);
    end
    rsp_ready = 1;
    tick();
    rsp_ready = 0;
    // Correct success code must clear the error.
    cu_valid = successful_decryption;
    req_valid = 1;
    tick();
    req_valid = 0;
    tick(); tick();
    tests_run++;
    if (rsp_valid !== 1'b1 || rsp_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL dec_ok: rsp_valid=%b err=%b required 1/0", rsp_valid, rsp_err);
    end
    rsp_ready = 1;
    tick();
    rsp_ready = 0;
    $display("[TB] decrypt c3e1 -> err with wrong code, ok with right code");
  endtask

  task automatic test_backpressure();
    cu_data_out = 16'hBEEF; cu_valid = successful_encryption;
    req_valid = 1; req_op = 0; req_data = 16'h0F0F;
    tick();
    req_valid = 0;
    tick(); tick();
    cu_data_out = 16'h0000; cu_valid = not_valid;  // must not leak into held response
    for (int i = 0; i < 5; i++) begin
      tests_run++;
      if (rsp_valid !== 1'b1 || rsp_data !== 16'hBEEF || rsp_err !== 1'b0 || req_ready !== 1'b0) begin
        tests_failed++;
        $display("FAIL bp_hold %0d: rsp_valid=%b data=%h err=%b req_ready=%b required 1/beef/0/0",
                 i, rsp_valid, rsp_data, rsp_err, req_ready);
      end
      tick();
    end
    rsp_ready = 1;
    tick();
    rsp_ready = 0;
    tests_run++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL bp_release: rsp_valid=%b req_ready=%b required 0/1", rsp_valid, req_ready);
    end
    $display("[TB] backpressure 5 cycles, data=%h", rsp_data);
  endtask

  task automatic test_key_wr();
    cu_data_out = 16'h1357; cu_valid = successful_encryption;
    req_valid = 1; req_op = 0; req_data = 16'h2468;
    tick();
    req_valid = 0;
    key_wr = 1; key_in = 32'hFFFF0000;
    tick();
    key_wr = 0;
    tests_run++;
    if (cu_key !== 32'h1234ABCD) begin
      tests_failed++;
      $display("FAIL key_in_wait: cu_key=%h required 1234abcd", cu_key);
    end
    tick();
    rsp_ready = 1;
    tick();
    rsp_ready = 0;
    key_wr = 1; key_in = 32'hFFFF0000; req_valid = 1; req_data = 16'h7777;
    #1;
    tests_run++;
    if (req_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL key_idle_ready: req_ready=%b required 0", req_ready);
    end
    tick();
    key_wr = 0;
    tests_run++;
    if (cu_key !== 32'hFFFF0000 || cu_opcode !== no_op) begin
      tests_failed++;
      $display("FAIL key_idle_load: cu_key=%h op=%0d required ffff0000/no_op", cu_key, cu_opcode);
    end
    tick();
    req_valid = 0;
    tests_run++;
    if (cu_opcode !== encrypt || cu_data_in !== 16'h7777) begin
      tests_failed++;
      $display("FAIL key_next_accept: op=%0d din=%h required encrypt/7777", cu_opcode, cu_data_in);
    end
    tick(); tick();
    rsp_ready = 1;
    tick();
    rsp_ready = 0;
    $display("[TB] key_wr: wait ignored, idle loaded key=%h", cu_key);
  endtask

  task automatic test_back_to_back();
    int last_accept;
    int accepts;
    last_accept = -1;
    accepts = 0;
    cu_valid = successful_encryption;
    rsp_ready = 1; req_valid = 1; req_op = 0; req_data = 16'hAAAA;
    for (int c = 0; c < 14; c++) begin
      #1;
      if (req_ready === 1'b1) begin
        if (last_accept >= 0) begin
          tests_run++;
          if (c - last_accept !== LAT + 2) begin
            tests_failed++;
            $display("FAIL b2b_spacing: %0d edges required %0d", c - last_accept, LAT + 2);
          end
        end
        last_accept = c;
        accepts++;
      end
      tick();
    end
    req_valid = 0;
    tests_run++;
    if (accepts !== 4) begin
      tests_failed++;
      $display("FAIL b2b_count: %0d accepts required 4", accepts);
    end
    // Drain the outstanding operation.
    for (int c = 0; c < 6; c++) tick();
    rsp_ready = 0;
    $display("[TB] back_to_back: %0d accepts", accepts);
  endtask

  task automatic test_reset_mid_wait();
    cu_valid = successful_encryption; cu_data_out = 16'h4321;
    req_valid = 1; req_op = 0; req_data = 16'h9999;
    tick();
    req_valid = 0;
    #2;
    rst = 1'b0;
    #1;
    tests_run++;
    if (cu_opcode !== no_op || cu_data_in !== 16'h0 || cu_key !== 32'h0 || rsp_valid !== 1'b0 || rsp_data !== 16'h0) begin
      tests_failed++;
      $display("FAIL rst_immediate: op=%0d din=%h key=%h rsp_valid=%b data=%h required no_op/0/0/0/0",
               cu_opcode, cu_data_in, cu_key, rsp_valid, rsp_data);
    end
    tick();
    #2;
    rst = 1'b1;
    req_valid = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      tests_run++;
      if (rsp_valid !== 1'b0 || req_ready !== 1'b0) begin
        tests_failed++;
        $display("FAIL rst_after %0d: rsp_valid=%b req_ready=%b required 0/0", i, rsp_valid, req_ready);
      end
    end
    req_valid = 0;
    key_wr = 1; key_in = 32'hCAFE0001;
    tick();
    key_wr = 0;
    #1;
    tests_run++;
    if (req_ready !== 1'b1 || cu_key !== 32'hCAFE0001) begin
      tests_failed++;
      $display("FAIL rst_rekey: req_ready=%b key=%h required 1/cafe0001", req_ready, cu_key);
    end
    $display("[TB] reset mid-wait: aborted, rekey=%h", cu_key);
  endtask

  initial begin
    test_reset();
    test_no_key();
    test_encrypt();
    test_decrypt_err();
    test_backpressure();
    test_key_wr();
    test_back_to_back();
    test_reset_mid_wait();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
